// File: rtl/latch_write_arbiter.sv
// Round-robin write sequencer for a bank of level-sensitive D latches.
// Each write drives lat_d, then frames a one-hot registered gate pulse with setup and hold windows.
module latch_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int NLATCH = 4,
    parameter int SETUP  = 1,
    parameter int PULSE  = 1,
    parameter int HOLD   = 1,
    localparam int AW    = $clog2(NLATCH),
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      lat_d,
    output logic [NLATCH-1:0]     lat_g,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic                  write_done
);

    localparam int CMAX = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                          : ((PULSE > HOLD) ? PULSE : HOLD);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_GATE, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic [NLATCH-1:0] lat_g_q, lat_g_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;

    logic              found;
    logic              accept;
    logic [GW-1:0]     winner;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % NREQ);
    endfunction

    // Search upward from rr_ptr with wrap-around; first valid requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
                found  = 1'b1;
                winner = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == GW'(k)) begin
                sel_addr = req_addr[k*AW +: AW];
                sel_data = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = rst_n && (state_q == S_IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d_d  = lat_d_q;
        lat_g_d  = lat_g_q;
        addr_d   = addr_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lat_d_d  = sel_data;
                    addr_d   = sel_addr;
                    grant_d  = winner;
                    rr_ptr_d = wrap_idx(int'(winner) + 1);
                    cnt_d    = CW'(SETUP);
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(1)) begin
                    lat_g_d         = '0;
                    lat_g_d[addr_q] = 1'b1;
                    cnt_d           = CW'(PULSE);
                    state_d         = S_GATE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GATE: begin
                if (cnt_q == CW'(1)) begin
                    lat_g_d = '0;
                    cnt_d   = CW'(HOLD);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset drops the gate on the same edge, even mid-pulse.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lat_d_q  <= '0;
            lat_g_q  <= '0;
            addr_q   <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_d_q  <= lat_d_d;
            lat_g_q  <= lat_g_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign lat_d      = lat_d_q;
    assign lat_g      = lat_g_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != S_IDLE);
    assign write_done = (state_q == S_HOLD) && (cnt_q == CW'(1));

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: default instance plus a SETUP=2/PULSE=3/HOLD=2 instance.
module tb_latch_write_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  req_valid,   req_valid_p;
    logic [7:0]  req_addr,    req_addr_p;
    logic [31:0] req_data,    req_data_p;
    logic [3:0]  req_ready,   req_ready_p;
    logic [7:0]  lat_d,       lat_d_p;
    logic [3:0]  lat_g,       lat_g_p;
    logic        busy,        busy_p;
    logic [1:0]  grant_id,    grant_id_p;
    logic        write_done,  write_done_p;

    latch_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .lat_d(lat_d), .lat_g(lat_g),
        .busy(busy), .grant_id(grant_id), .write_done(write_done)
    );

    latch_write_arbiter #(.SETUP(2), .PULSE(3), .HOLD(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_p), .req_addr(req_addr_p),
        .req_data(req_data_p), .req_ready(req_ready_p), .lat_d(lat_d_p), .lat_g(lat_g_p),
        .busy(busy_p), .grant_id(grant_id_p), .write_done(write_done_p)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Invariants on both instances, sampled on the falling edge.
    logic       prev_busy = 1'b0, prev_busy_p = 1'b0;
    logic [7:0] prev_lat_d, prev_lat_d_p;
    always @(negedge clk) begin
        check("inv_onehot_g", 32'($onehot0(lat_g)), 32'd1);
        check("inv_onehot_g_p", 32'($onehot0(lat_g_p)), 32'd1);
        if (busy)   check("inv_ready_busy", 32'(req_ready), 32'd0);
        if (busy_p) check("inv_ready_busy_p", 32'(req_ready_p), 32'd0);
        if (prev_busy && busy)     check("inv_lat_d_stable", 32'(lat_d), 32'(prev_lat_d));
        if (prev_busy_p && busy_p) check("inv_lat_d_stable_p", 32'(lat_d_p), 32'(prev_lat_d_p));
        prev_busy    <= busy;
        prev_busy_p  <= busy_p;
        prev_lat_d   <= lat_d;
        prev_lat_d_p <= lat_d_p;
    end

    typedef struct {
        int         req;
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] exp_ready;
        logic [3:0] exp_g;
    } wr_vec_t;

    typedef struct {
        logic [3:0]      mask;
        logic [3:0][1:0] seq;
    } arb_vec_t;

    wr_vec_t  wr_tab[4];
    arb_vec_t arb_tab[6];

    task automatic do_write(input wr_vec_t v);
        req_valid = '0;
        req_valid[v.req] = 1'b1;
        req_addr[v.req*2 +: 2] = v.addr;
        req_data[v.req*8 +: 8] = v.data;
        #1 check("wr_ready", 32'(req_ready), 32'(v.exp_ready));
        step();
        req_valid = '0;
        check("wr_setup_g", 32'(lat_g), 32'd0);
        check("wr_setup_d", 32'(lat_d), 32'(v.data));
        check("wr_setup_busy", 32'(busy), 32'd1);
        check("wr_grant", 32'(grant_id), 32'(v.req));
        step();
        check("wr_gate_g", 32'(lat_g), 32'(v.exp_g));
        check("wr_gate_d", 32'(lat_d), 32'(v.data));
        check("wr_gate_done", 32'(write_done), 32'd0);
        step();
        check("wr_hold_g", 32'(lat_g), 32'd0);
        check("wr_hold_d", 32'(lat_d), 32'(v.data));
        check("wr_hold_done", 32'(write_done), 32'd1);
        step();
        check("wr_idle_busy", 32'(busy), 32'd0);
        check("wr_idle_done", 32'(write_done), 32'd0);
        check("wr_idle_grant", 32'(grant_id), 32'(v.req));
    endtask

    task automatic run_pattern(input arb_vec_t v);
        int cyc;
        int waited;
        rst_n = 1'b0;
        step();
        req_valid = v.mask;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*2 +: 2] = 2'(i);
            req_data[i*8 +: 8] = 8'(8'h10 + i);
        end
        rst_n = 1'b1;
        #1;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (req_ready == 4'b0 && waited < 8) begin
                step();
                cyc++;
                waited++;
            end
            check("arb_ready", 32'(req_ready), 32'(4'b0001 << v.seq[k]));
            check("arb_accept_cycle", 32'(cyc), 32'(k * 4));
            step();
            cyc++;
            check("arb_grant", 32'(grant_id), 32'(v.seq[k]));
            check("arb_lat_d", 32'(lat_d), 32'(8'h10 + v.seq[k]));
        end
        req_valid = '0;
    endtask

    initial begin
        wr_tab[0] = '{2, 2'd3, 8'hA5, 4'b0100, 4'b1000};
        wr_tab[1] = '{0, 2'd0, 8'h3C, 4'b0001, 4'b0001};
        wr_tab[2] = '{1, 2'd2, 8'hFF, 4'b0010, 4'b0100};
        wr_tab[3] = '{3, 2'd1, 8'h5A, 4'b1000, 4'b0010};

        arb_tab[0] = '{4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}};
        arb_tab[1] = '{4'b1001, {2'd3, 2'd0, 2'd3, 2'd0}};
        arb_tab[2] = '{4'b0110, {2'd2, 2'd1, 2'd2, 2'd1}};
        arb_tab[3] = '{4'b1010, {2'd3, 2'd1, 2'd3, 2'd1}};
        arb_tab[4] = '{4'b1000, {2'd3, 2'd3, 2'd3, 2'd3}};
        arb_tab[5] = '{4'b0101, {2'd2, 2'd0, 2'd2, 2'd0}};

        rst_n       = 1'b0;
        req_valid   = 4'b1111;
        req_addr    = '0;
        req_data    = '0;
        req_valid_p = '0;
        req_addr_p  = '0;
        req_data_p  = '0;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_lat_d", 32'(lat_d), 32'd0);
        check("rst_lat_g", 32'(lat_g), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_done", 32'(write_done), 32'd0);
        check("rst_busy_p", 32'(busy_p), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) do_write(wr_tab[i]);

        for (int i = 0; i < 6; i++) run_pattern(arb_tab[i]);

        // Reset while requester 0's gate is high; requester 1 stays pending.
        rst_n = 1'b0;
        step();
        req_valid = 4'b0011;
        req_addr  = 8'b0000_0100;
        req_data  = 32'h0000_2211;
        rst_n = 1'b1;
        #1 check("mid_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0010;
        step();
        check("mid_gate_g", 32'(lat_g), 32'b0001);
        rst_n = 1'b0;
        step();
        check("mid_rst_g", 32'(lat_g), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_lat_d", 32'(lat_d), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("mid_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check("mid_grant1", 32'(grant_id), 32'd1);
        check("mid_lat_d1", 32'(lat_d), 32'h22);
        step();
        step();
        step();

        // Stretched timing: requester 1 held valid across two accepts, 8 cycles apart.
        req_valid_p = 4'b0010;
        req_addr_p  = 8'b0000_1000;
        req_data_p  = 32'h0000_3C00;
        #1;
        for (int c = 0; c <= 8; c++) begin
            check("p_ready", 32'(req_ready_p), (c == 0 || c == 8) ? 32'b0010 : 32'd0);
            check("p_lat_g", 32'(lat_g_p), (c >= 3 && c <= 5) ? 32'b0100 : 32'd0);
            check("p_busy", 32'(busy_p), (c >= 1 && c <= 7) ? 32'd1 : 32'd0);
            check("p_done", 32'(write_done_p), (c == 7) ? 32'd1 : 32'd0);
            if (c >= 1) check("p_lat_d", 32'(lat_d_p), 32'h3C);
            if (c < 8) step();
        end
        req_valid_p = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
